// File: rtl/bsr_block_sched.sv
// Walks a CSR-of-blocks image (row_ptr, col_idx, weight BRAMs) and streams each
// 8x8 INT8 block as eight tagged 64-bit beats through a 2-entry skid FIFO.
//
// state | meaning
// IDLE  | waiting for start
// RP0   | read row_ptr[0] (first row only)
// RP1   | read row_ptr[r+1]
// CHK   | validate row bounds, pick empty-row skip or first block
// COL   | read col_idx[b]
// BEAT  | issue eight weight reads for block b under FIFO credit
// DRAIN | wait for FIFO empty and no read in flight
// DONE  | one-cycle done (and error) pulse
module bsr_block_sched #(
  parameter int BRAM_ADDR_W = 10,
  parameter int ROW_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ROW_W-1:0]         num_rows,
  input  logic [ROW_W-1:0]         total_blocks,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic                     row_ptr_re,
  output logic [BRAM_ADDR_W-1:0]   row_ptr_raddr,
  input  logic [31:0]              row_ptr_rdata,
  output logic                     col_idx_re,
  output logic [BRAM_ADDR_W-1:0]   col_idx_raddr,
  input  logic [15:0]              col_idx_rdata,
  output logic                     wgt_re,
  output logic [BRAM_ADDR_W+2:0]   wgt_raddr,
  input  logic [63:0]              wgt_rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [63:0]              out_data,
  output logic [ROW_W-1:0]         out_row,
  output logic [ROW_W-1:0]         out_col,
  output logic [2:0]               out_beat,
  output logic                     out_blk_last,
  output logic                     out_row_last,
  output logic                     out_last
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RP0   = 3'd1;
  localparam logic [2:0] S_RP1   = 3'd2;
  localparam logic [2:0] S_CHK   = 3'd3;
  localparam logic [2:0] S_COL   = 3'd4;
  localparam logic [2:0] S_BEAT  = 3'd5;
  localparam logic [2:0] S_DRAIN = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  localparam int TAG_W = 2*ROW_W + 6;

  logic [2:0]       state;
  logic [ROW_W-1:0] nrows_q, tblk_q, r_q, rp_lo_q, rp_hi_q, b_q, col_q;
  logic [2:0]       beat_q;
  logic             lo_pend_q, lo_bad_q, col_fresh_q, fault_q;

  logic             infl_q;
  logic [TAG_W-1:0] infl_tag_q;

  logic [63:0]      fd_q [2];
  logic [TAG_W-1:0] ft_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       cnt_q;

  logic [ROW_W-1:0] r_inc, b_inc, rp_word, col_now;
  logic             rp_wide_bad, chk_fault, pop, credit_ok, issue;
  logic             tag_bl, tag_rl, tag_l;
  logic [TAG_W-1:0] head_tag;

  assign r_inc       = r_q + ROW_W'(1);
  assign b_inc       = b_q + ROW_W'(1);
  assign rp_word     = row_ptr_rdata[ROW_W-1:0];
  assign rp_wide_bad = |row_ptr_rdata[31:ROW_W];
  assign col_now     = col_fresh_q ? ROW_W'(col_idx_rdata) : col_q;

  assign chk_fault = lo_bad_q | rp_wide_bad | (rp_word < rp_lo_q) | (rp_word > tblk_q)
                   | ((r_inc == nrows_q) && (rp_word != tblk_q));

  // A popped slot frees this cycle, so it already counts as credit.
  assign pop       = out_valid & out_ready;
  assign credit_ok = ({1'b0, cnt_q} + {2'b00, infl_q}) < (3'd2 + {2'b00, pop});
  assign issue     = (state == S_BEAT) && credit_ok;

  assign tag_bl = (beat_q == 3'd7);
  assign tag_rl = tag_bl && !(b_inc < rp_hi_q);
  assign tag_l  = tag_bl && (b_q == tblk_q - ROW_W'(1));

  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);
  assign error = done & fault_q;

  assign row_ptr_re    = (state == S_RP0) || (state == S_RP1);
  assign row_ptr_raddr = (state == S_RP0) ? r_q[BRAM_ADDR_W-1:0] :
                         (state == S_RP1) ? r_inc[BRAM_ADDR_W-1:0] : '0;
  assign col_idx_re    = (state == S_COL);
  assign col_idx_raddr = col_idx_re ? b_q[BRAM_ADDR_W-1:0] : '0;
  assign wgt_re        = issue;
  assign wgt_raddr     = issue ? {b_q[BRAM_ADDR_W-1:0], beat_q} : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      nrows_q     <= '0;
      tblk_q      <= '0;
      r_q         <= '0;
      rp_lo_q     <= '0;
      rp_hi_q     <= '0;
      b_q         <= '0;
      col_q       <= '0;
      beat_q      <= '0;
      lo_pend_q   <= 1'b0;
      lo_bad_q    <= 1'b0;
      col_fresh_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            nrows_q  <= num_rows;
            tblk_q   <= total_blocks;
            r_q      <= '0;
            fault_q  <= 1'b0;
            lo_bad_q <= 1'b0;
            state    <= (num_rows == '0) ? S_DONE : S_RP0;
          end
        end
        S_RP0: begin
          lo_pend_q <= 1'b1;
          state     <= S_RP1;
        end
        S_RP1: begin
          if (lo_pend_q) begin
            rp_lo_q   <= rp_word;
            lo_bad_q  <= rp_wide_bad;
            lo_pend_q <= 1'b0;
          end
          state <= S_CHK;
        end
        S_CHK: begin
          rp_hi_q <= rp_word;
          if (chk_fault) begin
            fault_q <= 1'b1;
            state   <= S_DRAIN;
          end else if (rp_word == rp_lo_q) begin
            r_q     <= r_inc;
            rp_lo_q <= rp_word;
            state   <= (r_inc == nrows_q) ? S_DRAIN : S_RP1;
          end else begin
            b_q   <= rp_lo_q;
            state <= S_COL;
          end
        end
        S_COL: begin
          col_fresh_q <= 1'b1;
          beat_q      <= '0;
          state       <= S_BEAT;
        end
        S_BEAT: begin
          // col_idx data is only guaranteed the cycle after its read
          col_fresh_q <= 1'b0;
          col_q       <= col_now;
          if (issue) begin
            beat_q <= beat_q + 3'd1;
            if (beat_q == 3'd7) begin
              if (b_inc < rp_hi_q) begin
                b_q   <= b_inc;
                state <= S_COL;
              end else begin
                r_q     <= r_inc;
                rp_lo_q <= rp_hi_q;
                state   <= (r_inc == nrows_q) ? S_DRAIN : S_RP1;
              end
            end
          end
        end
        S_DRAIN: begin
          if (cnt_q == 2'd0 && !infl_q) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      infl_q     <= 1'b0;
      infl_tag_q <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fd_q[i] <= '0;
        ft_q[i] <= '0;
      end
    end else begin
      infl_q <= issue;
      if (issue) infl_tag_q <= {r_q, col_now, beat_q, tag_bl, tag_rl, tag_l};
      if (infl_q) begin
        fd_q[wr_ptr_q] <= wgt_rdata;
        ft_q[wr_ptr_q] <= infl_tag_q;
        wr_ptr_q       <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, infl_q} - {1'b0, pop};
    end
  end

  assign head_tag     = ft_q[rd_ptr_q];
  assign out_valid    = (cnt_q != 2'd0);
  assign out_data     = fd_q[rd_ptr_q];
  assign out_row      = head_tag[TAG_W-1 -: ROW_W];
  assign out_col      = head_tag[ROW_W+5 -: ROW_W];
  assign out_beat     = head_tag[5:3];
  assign out_blk_last = head_tag[2];
  assign out_row_last = head_tag[1];
  assign out_last     = head_tag[0];

endmodule
